// File: rtl/lsu_byte_sequencer.sv
// LSU initiator for an 8-bit dual-port RAM: splits one byte/half/word request
// into byte beats on ports A/B and returns a sign- or zero-extended response.
module lsu_byte_sequencer #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [7:0]        ram_wdata_a,
    output logic              ram_we_a,
    input  logic [7:0]        ram_rdata_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [7:0]        ram_wdata_b,
    output logic              ram_we_b,
    input  logic [7:0]        ram_rdata_b
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE0 = 3'd1,
        S_ISSUE1 = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       ext_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lo[0];
            SZ_WORD: m = (lo != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    // State and latched-request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

    // Next state, request latch and read-beat capture.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    buf_d   = 32'd0;
                    err_d   = is_misaligned(req_size, req_addr[1:0]);
                    state_d = err_d ? S_RESP : S_ISSUE0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE0: begin
                state_d = (size_q == SZ_WORD) ? S_ISSUE1 : S_DRAIN;
            end
            S_ISSUE1: begin
                // Read data for the ISSUE0 beat arrives one cycle late.
                buf_d[15:0] = {ram_rdata_b, ram_rdata_a};
                state_d     = S_DRAIN;
            end
            S_DRAIN: begin
                if (size_q == SZ_WORD) begin
                    buf_d[31:16] = {ram_rdata_b, ram_rdata_a};
                end else begin
                    buf_d[15:0] = {ram_rdata_b, ram_rdata_a};
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load extension of the assembled buffer.
    always_comb begin
        ext_s = buf_q;
        case (size_q)
            SZ_BYTE: ext_s = uns_q ? {24'd0, buf_q[7:0]} : {{24{buf_q[7]}}, buf_q[7:0]};
            SZ_HALF: ext_s = uns_q ? {16'd0, buf_q[15:0]} : {{16{buf_q[15]}}, buf_q[15:0]};
            default: ext_s = buf_q;
        endcase
    end

    // Port and handshake outputs, decoded only from registered state.
    always_comb begin
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = 32'd0;
        ram_addr_a  = '0;
        ram_addr_b  = '0;
        ram_wdata_a = 8'd0;
        ram_wdata_b = 8'd0;
        ram_we_a    = 1'b0;
        ram_we_b    = 1'b0;
        case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_ISSUE0: begin
                ram_addr_a = addr_q;
                ram_addr_b = addr_q + ADDR_W'(1);
                if (we_q) begin
                    ram_wdata_a = wdata_q[7:0];
                    ram_wdata_b = wdata_q[15:8];
                    ram_we_a    = 1'b1;
                    ram_we_b    = (size_q != SZ_BYTE);
                end else begin
                    ram_we_a = 1'b0;
                end
            end
            S_ISSUE1: begin
                ram_addr_a = addr_q + ADDR_W'(2);
                ram_addr_b = addr_q + ADDR_W'(3);
                if (we_q) begin
                    ram_wdata_a = wdata_q[23:16];
                    ram_wdata_b = wdata_q[31:24];
                    ram_we_a    = 1'b1;
                    ram_we_b    = 1'b1;
                end else begin
                    ram_we_a = 1'b0;
                end
            end
            S_DRAIN: begin
                if (size_q == SZ_WORD) begin
                    ram_addr_a = addr_q + ADDR_W'(2);
                    ram_addr_b = addr_q + ADDR_W'(3);
                end else begin
                    ram_addr_a = addr_q;
                    ram_addr_b = addr_q + ADDR_W'(1);
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? 32'd0 : ext_s;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Randomized and directed bench for lsu_byte_sequencer with a byte-array RAM
// and a byte-level reference memory model.
module tb_lsu_byte_sequencer;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
    logic [7:0]        ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;
    logic              ram_we_a, ram_we_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic       mem_clr;
    int         we_cnt = 0;
    int         coll_cnt = 0;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .ram_addr_a(ram_addr_a), .ram_wdata_a(ram_wdata_a), .ram_we_a(ram_we_a),
        .ram_rdata_a(ram_rdata_a),
        .ram_addr_b(ram_addr_b), .ram_wdata_b(ram_wdata_b), .ram_we_b(ram_we_b),
        .ram_rdata_b(ram_rdata_b)
    );

    // Dual-port RAM with registered reads, plus write/collision monitors.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 7 + 3);
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
        end
        ram_rdata_a <= mem[ram_addr_a];
        ram_rdata_b <= mem[ram_addr_b];
        if (ram_we_a || ram_we_b) we_cnt <= we_cnt + 1;
        if ((ram_we_a || ram_we_b) && ram_addr_a == ram_addr_b) coll_cnt <= coll_cnt + 1;
    end

    function automatic bit ref_misaligned(input int size, input int addr);
        return (size == 3) || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
    endfunction

    function automatic int ref_latency(input int size, input int addr);
        if (ref_misaligned(size, addr)) return 1;
        return (size == 2) ? 4 : 3;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit uns, input int addr);
        int n = 1 << size;
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(addr + k) % DEPTH]) << (8 * k));
        if (!uns && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input int size, input int addr, input logic [31:0] wd);
        for (int k = 0; k < (1 << size); k++) ref_mem[(addr + k) % DEPTH] = 8'(wd >> (8 * k));
    endtask

    // Issue one request, wait `hold` cycles with rsp_ready low, then consume it.
    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input int addr, input logic [31:0] wd, input int hold,
                          output logic [31:0] rd, output logic err, output int lat);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = ADDR_W'(addr); req_wdata = wd; rsp_ready = 1'b0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (n >= 20 || !rsp_valid) lat = 99;
        rd = rsp_rdata; err = rsp_err;
        repeat (hold) @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'd0; rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, need 0/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b} !== '0) begin
            errors++; $display("FAIL reset_ram: we=%b%b addr=%h/%h wd=%h/%h, need all 0",
                ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b);
        end
        rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b need 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic err; int lat;
        do_req(1'b1, 2'd2, 1'b0, 'h10, 32'hDEAD_BEEF, 0, rd, err, lat);
        ref_store(2, 'h10, 32'hDEAD_BEEF);
        checks++;
        if (lat !== 4 || rd !== 32'd0 || err !== 1'b0) begin
            errors++; $display("FAIL sw_rsp: lat=%0d rd=%h err=%b, need 4/0/0", lat, rd, err);
        end
        checks++;
        if ({mem['h13], mem['h12], mem['h11], mem['h10]} !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sw_ram: got %h%h%h%h need DEADBEEF", mem['h13], mem['h12], mem['h11], mem['h10]);
        end
        do_req(1'b0, 2'd2, 1'b0, 'h10, 32'd0, 0, rd, err, lat);
        checks++;
        if (lat !== 4 || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
            errors++; $display("FAIL lw: lat=%0d rd=%h err=%b, need 4/DEADBEEF/0", lat, rd, err);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic err; int lat;
        logic [7:0] b4, b6;
        b4 = mem['h04]; b6 = mem['h06];
        do_req(1'b1, 2'd0, 1'b0, 'h05, 32'h1234_5680, 0, rd, err, lat);
        ref_store(0, 'h05, 32'h1234_5680);
        checks++;
        if (mem['h05] !== 8'h80 || mem['h04] !== b4 || mem['h06] !== b6) begin
            errors++; $display("FAIL sb_ram: [4..6]=%h %h %h need %h 80 %h", mem['h04], mem['h05], mem['h06], b4, b6);
        end
        do_req(1'b0, 2'd0, 1'b0, 'h05, 32'd0, 0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFF_FF80 || lat !== 3) begin errors++; $display("FAIL lb: rd=%h lat=%0d need FFFFFF80/3", rd, lat); end
        do_req(1'b0, 2'd0, 1'b1, 'h05, 32'd0, 0, rd, err, lat);
        checks++;
        if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu: rd=%h need 00000080", rd); end
        do_req(1'b1, 2'd1, 1'b0, 'h102, 32'hABCD_8001, 0, rd, err, lat);
        ref_store(1, 'h102, 32'hABCD_8001);
        checks++;
        if (mem['h102] !== 8'h01 || mem['h103] !== 8'h80 || lat !== 3) begin
            errors++; $display("FAIL sh: ram=%h%h lat=%0d need 8001/3", mem['h103], mem['h102], lat);
        end
        do_req(1'b0, 2'd1, 1'b0, 'h102, 32'd0, 0, rd, err, lat);
        checks++;
        if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh: rd=%h need FFFF8001", rd); end
        do_req(1'b0, 2'd1, 1'b1, 'h102, 32'd0, 0, rd, err, lat);
        checks++;
        if (rd !== 32'h0000_8001) begin errors++; $display("FAIL lhu: rd=%h need 00008001", rd); end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic err; int lat; int w0;
        w0 = we_cnt;
        do_req(1'b0, 2'd2, 1'b0, 'h11, 32'd0, 0, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++; $display("FAIL lw_mis: err=%b rd=%h lat=%0d need 1/0/1", err, rd, lat);
        end
        do_req(1'b0, 2'd1, 1'b0, 'h03, 32'd0, 0, rd, err, lat);
        checks++;
        if (err !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
            errors++; $display("FAIL lh_mis: err=%b rd=%h lat=%0d need 1/0/1", err, rd, lat);
        end
        do_req(1'b1, 2'd3, 1'b0, 'h20, 32'hFFFF_FFFF, 0, rd, err, lat);
        checks++;
        if (err !== 1'b1 || lat !== 1 || we_cnt != w0) begin
            errors++; $display("FAIL sz3_st: err=%b lat=%0d writes=%0d need 1/1/0", err, lat, we_cnt - w0);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0; bit stable = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = ADDR_W'('h10); rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || req_ready !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL hold: valid=%b rdata=%h ready=%b need 1/DEADBEEF/0", rsp_valid, rsp_rdata, req_ready); end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_size = 2'd0; req_unsigned = 1'b1; req_addr = ADDR_W'('h05);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL resp_ready: got %b need 0", req_ready); end
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept: req_ready=%b need 1", req_ready); end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++;
        if (lat !== 3 || rsp_rdata !== 32'h0000_0080) begin
            errors++; $display("FAIL b2b_rsp: lat=%0d rd=%h need 3/00000080", lat, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midword();
        logic [7:0] b2, b3; bit seen = 1'b0;
        b2 = mem['h202]; b3 = mem['h203];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = ADDR_W'('h200);
        req_wdata = 32'h1122_3344;
        @(posedge clk); #1 req_valid = 1'b0;
        // rst is sampled on the edge that would enter ISSUE1
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ref_store(1, 'h200, 32'h0000_3344);
        @(negedge clk);
        checks++;
        if ({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_wdata_a, ram_wdata_b, rsp_valid} !== '0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_out: we=%b%b addr=%h/%h valid=%b ready=%b need idle zeros",
                ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, rsp_valid, req_ready);
        end
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
        checks++;
        if (seen || mem['h202] !== b2 || mem['h203] !== b3 || mem['h200] !== 8'h44) begin
            errors++; $display("FAIL midrst_ram: rspseen=%b [200..203]=%h %h %h %h need 44 33 %h %h",
                seen, mem['h200], mem['h201], mem['h202], mem['h203], b2, b3);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_rd; logic err; int lat, size, addr, w0; bit we, uns, is_err;
        for (int t = 0; t < 80; t++) begin
            size = $urandom_range(0, 3);
            addr = $urandom_range(0, 63);
            we = $urandom_range(0, 1); uns = $urandom_range(0, 1);
            wd = $urandom;
            is_err = ref_misaligned(size, addr);
            exp_rd = (we || is_err) ? 32'd0 : ref_load(size, uns, addr);
            w0 = we_cnt;
            do_req(we, 2'(size), uns, addr, wd, $urandom_range(0, 2), rd, err, lat);
            if (we && !is_err) ref_store(size, addr, wd);
            checks++;
            if (rd !== exp_rd || err !== is_err || lat !== ref_latency(size, addr) || (is_err && we_cnt != w0)) begin
                errors++; $display("FAIL rand%0d: we=%0d sz=%0d a=%h rd=%h err=%b lat=%0d need rd=%h err=%b lat=%0d",
                    t, we, size, addr, rd, err, lat, exp_rd, is_err, ref_latency(size, addr));
            end
        end
        for (int a = 0; a < 72; a++) begin
            checks++;
            if (mem[a] !== ref_mem[a]) begin errors++; $display("FAIL ram_final[%0h]: got %h need %h", a, mem[a], ref_mem[a]); end
        end
        checks++;
        if (coll_cnt != 0) begin errors++; $display("FAIL port_collision: count=%0d need 0", coll_cnt); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_back_to_back();
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
